// File: rtl/pqr5_core_pkg.sv
// Shared PQR5 core definitions: branch funct3 encodings, link registers, RAS operations.
package pqr5_core_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [4:0] LINK_X1 = 5'd1;
    localparam logic [4:0] LINK_X5 = 5'd5;

    typedef enum logic [1:0] {
        RAS_NONE    = 2'd0,
        RAS_PUSH    = 2'd1,
        RAS_POP     = 2'd2,
        RAS_POPPUSH = 2'd3
    } ras_op_t;

    function automatic logic is_link(input logic [4:0] r);
        return (r == LINK_X1) || (r == LINK_X5);
    endfunction

endpackage

// File: rtl/bu_ras.sv
// Committed return-address stack: circular buffer whose pointer addresses the top entry.
module bu_ras
    import pqr5_core_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            aresetn,
    input  ras_op_t         i_op,
    input  logic [XLEN-1:0] i_data,
    output logic [XLEN-1:0] o_top,
    output logic            o_valid
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    logic [XLEN-1:0] mem_r [RAS_DEPTH];
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   ptr_nxt_s;
    logic [PW-1:0]   wr_idx_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic            wr_en_s;
    logic            do_push_s;

    // Next pointer/count; a pop-and-push on an empty stack degenerates to a push.
    always_comb begin
        ptr_nxt_s = ptr_r;
        cnt_nxt_s = cnt_r;
        wr_en_s   = 1'b0;
        wr_idx_s  = ptr_r;
        do_push_s = 1'b0;
        case (i_op)
            RAS_PUSH:    do_push_s = 1'b1;
            RAS_POP: begin
                if (cnt_r != CNT_ZERO) begin
                    ptr_nxt_s = ptr_r - 1'b1;
                    cnt_nxt_s = cnt_r - 1'b1;
                end else begin
                    ptr_nxt_s = ptr_r;
                end
            end
            RAS_POPPUSH: begin
                if (cnt_r == CNT_ZERO) begin
                    do_push_s = 1'b1;
                end else begin
                    wr_en_s = 1'b1;
                end
            end
            default:     do_push_s = 1'b0;
        endcase
        if (do_push_s) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = ptr_r + 1'b1;
            ptr_nxt_s = ptr_r + 1'b1;
            cnt_nxt_s = (cnt_r == CNT_FULL) ? cnt_r : cnt_r + 1'b1;
        end else begin
            wr_idx_s = wr_idx_s;
        end
    end

    // Stack storage, pointer and occupancy.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_r[i] <= {XLEN{1'b0}};
            end
            ptr_r <= {PW{1'b0}};
            cnt_r <= CNT_ZERO;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_idx_s] <= i_data;
            end
            ptr_r <= ptr_nxt_s;
            cnt_r <= cnt_nxt_s;
        end
    end

    assign o_top   = mem_r[ptr_r];
    assign o_valid = (cnt_r != CNT_ZERO);

endmodule

// File: rtl/exu_branch_resolve_unit.sv
// PQR5 EXU branch resolve unit: JAL/JALR/B-type resolution, flush, misalign and committed RAS.
// Optional performance counters are enabled with `define PQR5_BU_PERF_CNT_EN.
module exu_branch_resolve_unit
    import pqr5_core_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] PC_INIT   = {XLEN{1'b0}},
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            aresetn,
    input  logic            i_stall,
    input  logic            i_bubble,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pred_pc,
    input  logic            i_is_jal,
    input  logic            i_is_jalr,
    input  logic            i_is_branch,
    input  logic [2:0]      i_funct3,
    input  logic [4:0]      i_rd,
    input  logic [4:0]      i_rs1,
    input  logic [19:0]     i_immJ,
    input  logic [11:0]     i_immI,
    input  logic [11:0]     i_immB,
    input  logic [XLEN-1:0] i_op0,
    input  logic [XLEN-1:0] i_op1,
    output logic [XLEN-1:0] o_nxt_instr_pc,
    output logic            o_bubble,
    output logic            o_branch_taken,
    output logic [XLEN-1:0] o_branch_pc,
    output logic            o_flush,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_ras_top,
    output logic            o_ras_valid
`ifdef PQR5_BU_PERF_CNT_EN
    ,
    output logic [31:0]     o_perf_ctl_cnt,
    output logic [31:0]     o_perf_flush_cnt
`endif
);

    localparam logic [XLEN-1:0] FOUR = XLEN'(32'd4);

    logic            valid_s;
    logic [XLEN-1:0] pc4_s;
    logic [XLEN-1:0] jal_tgt_s;
    logic [XLEN-1:0] jalr_tgt_s;
    logic [XLEN-1:0] br_tgt_s;
    logic [XLEN-1:0] nxt_pc_s;
    logic            br_legal_s;
    logic            br_cond_s;
    logic            ctl_s;
    logic            dir_s;
    logic            misalign_s;
    logic            flush_s;
    logic            link_ok_s;
    logic            push_s;
    logic            pop_s;
    ras_op_t         ras_op_s;
    logic [XLEN-1:0] ras_top_s;
    logic            ras_valid_s;

    assign valid_s    = !i_bubble && !i_stall;
    assign pc4_s      = i_pc + FOUR;
    assign jal_tgt_s  = i_pc + {{(XLEN-21){i_immJ[19]}}, i_immJ, 1'b0};
    assign jalr_tgt_s = (i_op0 + {{(XLEN-12){i_immI[11]}}, i_immI}) & ~{{(XLEN-1){1'b0}}, 1'b1};
    assign br_tgt_s   = i_pc + {{(XLEN-13){i_immB[11]}}, i_immB, 1'b0};

    // Branch condition; unknown funct3 is not treated as a control transfer.
    always_comb begin
        br_legal_s = 1'b1;
        br_cond_s  = 1'b0;
        case (i_funct3)
            F3_BEQ:  br_cond_s = (i_op0 == i_op1);
            F3_BNE:  br_cond_s = (i_op0 != i_op1);
            F3_BLT:  br_cond_s = ($signed(i_op0) <  $signed(i_op1));
            F3_BGE:  br_cond_s = ($signed(i_op0) >= $signed(i_op1));
            F3_BLTU: br_cond_s = (i_op0 <  i_op1);
            F3_BGEU: br_cond_s = (i_op0 >= i_op1);
            default: br_legal_s = 1'b0;
        endcase
    end

    // Resolved next PC and direction; bubbles and non-control slots fall through to PC+4.
    always_comb begin
        ctl_s    = 1'b0;
        dir_s    = 1'b0;
        nxt_pc_s = pc4_s;
        if (valid_s && i_is_jal) begin
            ctl_s    = 1'b1;
            dir_s    = 1'b1;
            nxt_pc_s = jal_tgt_s;
        end else if (valid_s && i_is_jalr) begin
            ctl_s    = 1'b1;
            dir_s    = 1'b1;
            nxt_pc_s = jalr_tgt_s;
        end else if (valid_s && i_is_branch && br_legal_s) begin
            ctl_s    = 1'b1;
            dir_s    = br_cond_s;
            nxt_pc_s = br_cond_s ? br_tgt_s : pc4_s;
        end else begin
            nxt_pc_s = pc4_s;
        end
    end

    assign misalign_s = ctl_s && nxt_pc_s[1];
    assign flush_s    = ctl_s && (misalign_s || (nxt_pc_s != i_pred_pc));

    assign link_ok_s = ctl_s && (i_is_jal || i_is_jalr) && !misalign_s;
    assign push_s    = link_ok_s && is_link(i_rd);
    assign pop_s     = link_ok_s && i_is_jalr && is_link(i_rs1)
                       && !(is_link(i_rd) && (i_rd == i_rs1));

    // RAS operation encoding.
    always_comb begin
        ras_op_s = RAS_NONE;
        if (push_s && pop_s) begin
            ras_op_s = RAS_POPPUSH;
        end else if (push_s) begin
            ras_op_s = RAS_PUSH;
        end else if (pop_s) begin
            ras_op_s = RAS_POP;
        end else begin
            ras_op_s = RAS_NONE;
        end
    end

    bu_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .aresetn (aresetn),
        .i_op    (ras_op_s),
        .i_data  (pc4_s),
        .o_top   (ras_top_s),
        .o_valid (ras_valid_s)
    );

    assign o_ras_valid = ras_valid_s;
    assign o_ras_top   = ras_valid_s ? ras_top_s : PC_INIT;

    // Result registers; a stall holds every output.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_nxt_instr_pc <= PC_INIT;
            o_branch_pc    <= PC_INIT;
            o_bubble       <= 1'b1;
            o_branch_taken <= 1'b0;
            o_flush        <= 1'b0;
            o_misalign     <= 1'b0;
        end else if (!i_stall) begin
            o_nxt_instr_pc <= pc4_s;
            o_branch_pc    <= nxt_pc_s;
            o_bubble       <= !link_ok_s;
            o_branch_taken <= dir_s && !misalign_s;
            o_flush        <= flush_s;
            o_misalign     <= misalign_s;
        end
    end

`ifdef PQR5_BU_PERF_CNT_EN
    // Event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            o_perf_ctl_cnt   <= 32'd0;
            o_perf_flush_cnt <= 32'd0;
        end else begin
            o_perf_ctl_cnt   <= o_perf_ctl_cnt   + {31'd0, ctl_s};
            o_perf_flush_cnt <= o_perf_flush_cnt + {31'd0, flush_s};
        end
    end
`else
    // Counters compiled out.
`endif

endmodule

// File: tb/tb_exu_branch_resolve_unit.sv
// Directed self-checking bench for exu_branch_resolve_unit (default XLEN=32, RAS_DEPTH=4).
module tb_exu_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        i_stall, i_bubble, i_is_jal, i_is_jalr, i_is_branch;
    logic [31:0] i_pc, i_pred_pc, i_op0, i_op1;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd, i_rs1;
    logic [19:0] i_immJ;
    logic [11:0] i_immI, i_immB;
    logic [31:0] o_nxt_instr_pc, o_branch_pc, o_ras_top;
    logic        o_bubble, o_branch_taken, o_flush, o_misalign, o_ras_valid;

    int checks = 0;
    int failures = 0;

    exu_branch_resolve_unit dut (
        .clk(clk), .aresetn(aresetn), .i_stall(i_stall), .i_bubble(i_bubble),
        .i_pc(i_pc), .i_pred_pc(i_pred_pc), .i_is_jal(i_is_jal), .i_is_jalr(i_is_jalr),
        .i_is_branch(i_is_branch), .i_funct3(i_funct3), .i_rd(i_rd), .i_rs1(i_rs1),
        .i_immJ(i_immJ), .i_immI(i_immI), .i_immB(i_immB), .i_op0(i_op0), .i_op1(i_op1),
        .o_nxt_instr_pc(o_nxt_instr_pc), .o_bubble(o_bubble), .o_branch_taken(o_branch_taken),
        .o_branch_pc(o_branch_pc), .o_flush(o_flush), .o_misalign(o_misalign),
        .o_ras_top(o_ras_top), .o_ras_valid(o_ras_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        i_stall = 1'b0; i_bubble = 1'b0; i_is_jal = 1'b0; i_is_jalr = 1'b0; i_is_branch = 1'b0;
        i_pc = 32'h0; i_pred_pc = 32'h0; i_op0 = 32'h0; i_op1 = 32'h0; i_funct3 = 3'd0;
        i_rd = 5'd0; i_rs1 = 5'd0; i_immJ = 20'h0; i_immI = 12'h0; i_immB = 12'h0;
    endtask

    task automatic do_jal(input logic [31:0] pc, input logic [4:0] rd, input logic [19:0] imm,
                          input logic [31:0] pred);
        clr(); i_is_jal = 1'b1; i_pc = pc; i_rd = rd; i_immJ = imm; i_pred_pc = pred;
        step();
    endtask

    task automatic do_jalr(input logic [31:0] pc, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [31:0] op0, input logic [11:0] imm, input logic [31:0] pred);
        clr(); i_is_jalr = 1'b1; i_pc = pc; i_rd = rd; i_rs1 = rs1; i_op0 = op0; i_immI = imm;
        i_pred_pc = pred;
        step();
    endtask

    task automatic do_br(input logic [31:0] pc, input logic [2:0] f3, input logic [11:0] imm,
                         input logic [31:0] op0, input logic [31:0] op1, input logic [31:0] pred);
        clr(); i_is_branch = 1'b1; i_pc = pc; i_funct3 = f3; i_immB = imm; i_op0 = op0;
        i_op1 = op1; i_pred_pc = pred;
        step();
    endtask

    task automatic test_reset();
        clr(); aresetn = 1'b0;
        repeat (2) step();
        checks++; if (o_bubble !== 1'b1) begin failures++; $display("FAIL rst_bubble got=%0h exp=1", o_bubble); end
        checks++; if (o_branch_taken !== 1'b0) begin failures++; $display("FAIL rst_taken got=%0h exp=0", o_branch_taken); end
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL rst_flush got=%0h exp=0", o_flush); end
        checks++; if (o_branch_pc !== 32'h0) begin failures++; $display("FAIL rst_bpc got=%0h exp=0", o_branch_pc); end
        checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL rst_rasv got=%0h exp=0", o_ras_valid); end
        aresetn = 1'b1;
        step();
    endtask

    task automatic test_branch();
        do_br(32'h100, 3'b000, 12'h008, 32'd5, 32'd5, 32'h104);
        checks++; if (o_branch_taken !== 1'b1) begin failures++; $display("FAIL beq_taken got=%0h exp=1", o_branch_taken); end
        checks++; if (o_branch_pc !== 32'h110) begin failures++; $display("FAIL beq_bpc got=%0h exp=110", o_branch_pc); end
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL beq_flush got=%0h exp=1", o_flush); end
        checks++; if (o_nxt_instr_pc !== 32'h104) begin failures++; $display("FAIL beq_link got=%0h exp=104", o_nxt_instr_pc); end
        do_br(32'h100, 3'b000, 12'h008, 32'd5, 32'd5, 32'h110);
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL beq_pred_flush got=%0h exp=0", o_flush); end
        checks++; if (o_bubble !== 1'b1) begin failures++; $display("FAIL beq_pred_bubble got=%0h exp=1", o_bubble); end
        // Not-taken BNE whose predictor followed the target: must flush back to PC+4.
        do_br(32'h100, 3'b001, 12'hFF8, 32'd7, 32'd7, 32'h0F0);
        checks++; if (o_branch_pc !== 32'h104) begin failures++; $display("FAIL bne_nt_bpc got=%0h exp=104", o_branch_pc); end
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL bne_nt_flush got=%0h exp=1", o_flush); end
        do_br(32'h100, 3'b001, 12'hFF8, 32'd7, 32'd8, 32'h0F0);
        checks++; if (o_branch_pc !== 32'h0F0) begin failures++; $display("FAIL bne_back_bpc got=%0h exp=f0", o_branch_pc); end
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL bne_back_flush got=%0h exp=0", o_flush); end
    endtask

    task automatic test_jal_jalr();
        do_jal(32'h200, 5'd1, 20'h0, 32'h200);
        checks++; if (o_ras_valid !== 1'b1) begin failures++; $display("FAIL jal_rasv got=%0h exp=1", o_ras_valid); end
        checks++; if (o_ras_top !== 32'h204) begin failures++; $display("FAIL jal_rastop got=%0h exp=204", o_ras_top); end
        checks++; if (o_bubble !== 1'b0) begin failures++; $display("FAIL jal_bubble got=%0h exp=0", o_bubble); end
        do_jalr(32'h300, 5'd0, 5'd1, 32'h204, 12'h0, 32'h204);
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL ret_flush got=%0h exp=0", o_flush); end
        checks++; if (o_branch_pc !== 32'h204) begin failures++; $display("FAIL ret_bpc got=%0h exp=204", o_branch_pc); end
        checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL ret_rasv got=%0h exp=0", o_ras_valid); end
        // JALR rd=x1, rs1=x5: pop and push together replaces the top in place.
        do_jal(32'h500, 5'd1, 20'h0, 32'h500);
        do_jalr(32'h600, 5'd1, 5'd5, 32'h801, 12'hFFF, 32'h900);
        checks++; if (o_branch_pc !== 32'h800) begin failures++; $display("FAIL jalr_bpc got=%0h exp=800", o_branch_pc); end
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL jalr_flush got=%0h exp=1", o_flush); end
        checks++; if (o_ras_top !== 32'h604) begin failures++; $display("FAIL poppush_top got=%0h exp=604", o_ras_top); end
        do_jalr(32'h700, 5'd0, 5'd1, 32'h604, 12'h0, 32'h604);
        checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL poppush_pop_rasv got=%0h exp=0", o_ras_valid); end
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_top [4];
        exp_top[0] = 32'h40; exp_top[1] = 32'h30; exp_top[2] = 32'h20; exp_top[3] = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            do_jal(32'(k * 16 - 4), 5'd1, 20'h0, 32'(k * 16 - 4));
            checks++; if (o_ras_top !== 32'(k * 16)) begin failures++; $display("FAIL push%0d_top got=%0h exp=%0h", k, o_ras_top, k * 16); end
        end
        for (int k = 0; k < 5; k++) begin
            do_jalr(32'h3F0, 5'd0, 5'd1, 32'h400, 12'h0, 32'h400);
            if (k < 3) begin
                checks++; if (o_ras_top !== exp_top[k]) begin failures++; $display("FAIL pop%0d_top got=%0h exp=%0h", k, o_ras_top, exp_top[k]); end
            end else begin
                checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL pop%0d_rasv got=%0h exp=0", k, o_ras_valid); end
            end
        end
    endtask

    task automatic test_misalign_compare();
        do_jalr(32'h40, 5'd1, 5'd2, 32'h1002, 12'h0, 32'h1002);
        checks++; if (o_misalign !== 1'b1) begin failures++; $display("FAIL mis_flag got=%0h exp=1", o_misalign); end
        checks++; if (o_flush !== 1'b1) begin failures++; $display("FAIL mis_flush got=%0h exp=1", o_flush); end
        checks++; if (o_bubble !== 1'b1) begin failures++; $display("FAIL mis_bubble got=%0h exp=1", o_bubble); end
        checks++; if (o_branch_taken !== 1'b0) begin failures++; $display("FAIL mis_taken got=%0h exp=0", o_branch_taken); end
        checks++; if (o_branch_pc !== 32'h1002) begin failures++; $display("FAIL mis_bpc got=%0h exp=1002", o_branch_pc); end
        checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL mis_rasv got=%0h exp=0", o_ras_valid); end
        do_br(32'h80, 3'b110, 12'h010, 32'hFFFF_FFFF, 32'd1, 32'h84);
        checks++; if (o_branch_taken !== 1'b0) begin failures++; $display("FAIL bltu_taken got=%0h exp=0", o_branch_taken); end
        checks++; if (o_branch_pc !== 32'h84) begin failures++; $display("FAIL bltu_bpc got=%0h exp=84", o_branch_pc); end
        do_br(32'h80, 3'b100, 12'h010, 32'hFFFF_FFFF, 32'd1, 32'h84);
        checks++; if (o_branch_taken !== 1'b1) begin failures++; $display("FAIL blt_taken got=%0h exp=1", o_branch_taken); end
        checks++; if (o_branch_pc !== 32'hA0) begin failures++; $display("FAIL blt_bpc got=%0h exp=a0", o_branch_pc); end
        do_br(32'h80, 3'b101, 12'h010, 32'hFFFF_FFFF, 32'd1, 32'h84);
        checks++; if (o_branch_taken !== 1'b0) begin failures++; $display("FAIL bge_taken got=%0h exp=0", o_branch_taken); end
        do_br(32'h80, 3'b111, 12'h010, 32'hFFFF_FFFF, 32'd1, 32'h84);
        checks++; if (o_branch_taken !== 1'b1) begin failures++; $display("FAIL bgeu_taken got=%0h exp=1", o_branch_taken); end
    endtask

    task automatic test_back_to_back();
        do_br(32'h500, 3'b010, 12'h010, 32'd1, 32'd1, 32'h520);
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL illegal_flush got=%0h exp=0", o_flush); end
        checks++; if (o_branch_pc !== 32'h504) begin failures++; $display("FAIL illegal_bpc got=%0h exp=504", o_branch_pc); end
        clr(); i_bubble = 1'b1; i_is_jal = 1'b1; i_pc = 32'h600; i_rd = 5'd1; i_immJ = 20'h00100; i_pred_pc = 32'h0;
        step();
        checks++; if (o_branch_pc !== 32'h604) begin failures++; $display("FAIL bub_bpc got=%0h exp=604", o_branch_pc); end
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL bub_flush got=%0h exp=0", o_flush); end
        checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL bub_rasv got=%0h exp=0", o_ras_valid); end
        do_jal(32'hFFFF_FFF0, 5'd0, 20'h00010, 32'h10);
        checks++; if (o_branch_pc !== 32'h10) begin failures++; $display("FAIL wrap_bpc got=%0h exp=10", o_branch_pc); end
        checks++; if (o_nxt_instr_pc !== 32'hFFFF_FFF4) begin failures++; $display("FAIL wrap_link got=%0h exp=fffffff4", o_nxt_instr_pc); end
        checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL wrap_flush got=%0h exp=0", o_flush); end
    endtask

    task automatic test_stall_reset();
        do_jal(32'h300, 5'd5, 20'h00010, 32'h320);
        clr(); i_stall = 1'b1; i_is_jalr = 1'b1; i_pc = 32'h900; i_rs1 = 5'd5; i_op0 = 32'h800; i_pred_pc = 32'h0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++; if (o_branch_pc !== 32'h320) begin failures++; $display("FAIL stall%0d_bpc got=%0h exp=320", c, o_branch_pc); end
            checks++; if (o_flush !== 1'b0) begin failures++; $display("FAIL stall%0d_flush got=%0h exp=0", c, o_flush); end
            checks++; if (o_ras_top !== 32'h304) begin failures++; $display("FAIL stall%0d_rastop got=%0h exp=304", c, o_ras_top); end
        end
        #2 aresetn = 1'b0;
        #1;
        checks++; if (o_branch_pc !== 32'h0) begin failures++; $display("FAIL arst_bpc got=%0h exp=0", o_branch_pc); end
        checks++; if (o_bubble !== 1'b1) begin failures++; $display("FAIL arst_bubble got=%0h exp=1", o_bubble); end
        checks++; if (o_ras_valid !== 1'b0) begin failures++; $display("FAIL arst_rasv got=%0h exp=0", o_ras_valid); end
        checks++; if (o_ras_top !== 32'h0) begin failures++; $display("FAIL arst_rastop got=%0h exp=0", o_ras_top); end
        checks++; if (o_nxt_instr_pc !== 32'h0) begin failures++; $display("FAIL arst_link got=%0h exp=0", o_nxt_instr_pc); end
        clr();
        step();
        aresetn = 1'b1;
        step();
    endtask

    initial begin
        clr();
        aresetn = 1'b0;
        test_reset();
        test_branch();
        test_jal_jalr();
        test_ras_overflow();
        test_misalign_compare();
        test_back_to_back();
        test_stall_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
